// File: rtl/soc_system_benchmark_pkg.sv
// Shared definitions for the benchmark timer: register map, channel FSM encoding
// and STATUS bit positions.
package soc_system_benchmark_pkg;

    localparam logic [1:0] REG_LAST   = 2'd0;
    localparam logic [1:0] REG_MAX    = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned STATUS_RUN_BIT = 0;
    localparam int unsigned STATUS_OVF_BIT = 1;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } bm_state_e;

endpackage

// File: rtl/soc_system_benchmark_timer_if.sv
// Avalon-MM slave bus of the benchmark timer, with master (CPU side) and slave
// (timer side) views.
interface soc_system_benchmark_timer_if;

    logic [4:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/soc_system_benchmark_channel.sv
// One marker channel: rise detector, IDLE/RUN FSM and pulse-width statistics
// (last, max, count, sticky overflow).
module soc_system_benchmark_channel
    import soc_system_benchmark_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             marker_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] last_o,
    output logic [CNT_W-1:0] max_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o,
    output logic             run_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    bm_state_e        state_q, state_d;
    logic             marker_q, marker_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             rise;

    assign rise = marker_i & ~marker_q;

    // marker_q resets high so a marker already asserted is not seen as a rise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            marker_q  <= 1'b1;
            elapsed_q <= '0;
            last_q    <= '0;
            max_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            marker_q  <= marker_d;
            elapsed_q <= elapsed_d;
            last_q    <= last_d;
            max_q     <= max_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (rise) state_d = StRun;
                StRun:   if (!marker_i) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Clear dominates a coincident capture, so nothing is recorded that cycle.
    always_comb begin
        marker_d  = marker_i;
        elapsed_d = elapsed_q;
        last_d    = last_q;
        max_d     = max_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (clear_i) begin
            elapsed_d = '0;
            last_d    = '0;
            max_d     = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) elapsed_d = CNT_W'(1);
                end
                StRun: begin
                    if (marker_i) begin
                        if (elapsed_q == CntMax) ovf_d = 1'b1;
                        else                     elapsed_d = elapsed_q + CNT_W'(1);
                    end else begin
                        last_d = elapsed_q;
                        if (elapsed_q > max_q) max_d = elapsed_q;
                        if (count_q != CntMax) count_d = count_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign last_o  = last_q;
    assign max_o   = max_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign run_o   = (state_q == StRun);

endmodule

// File: rtl/soc_system_benchmark_timer.sv
// Benchmark timer top: N_CH marker channels behind an Avalon-MM register file
// with a registered read port.
module soc_system_benchmark_timer
    import soc_system_benchmark_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CH-1:0]              markers,
    soc_system_benchmark_timer_if.slave  bus
);

    logic [2:0]       addr_ch;
    logic [1:0]       addr_reg;
    logic             rd_en;
    logic             wr_clear;
    logic [N_CH-1:0]  clear;
    logic [N_CH-1:0]  ovf_w;
    logic [N_CH-1:0]  run_w;
    logic [CNT_W-1:0] last_w  [N_CH];
    logic [CNT_W-1:0] max_w   [N_CH];
    logic [CNT_W-1:0] count_w [N_CH];
    logic [31:0]      sel_data;
    logic [31:0]      readdata_q, readdata_d;
    logic             unused_wdata;

    assign addr_ch      = bus.address[4:2];
    assign addr_reg     = bus.address[1:0];
    assign rd_en        = bus.chipselect & ~bus.read_n;
    assign wr_clear     = bus.chipselect & ~bus.write_n & (addr_reg == REG_STATUS) &
                          bus.writedata[0];
    assign unused_wdata = ^bus.writedata[31:1];

    always_comb begin
        clear = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            clear[i] = wr_clear && (addr_ch == 3'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        soc_system_benchmark_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk_i   (clk),
            .reset_i (reset),
            .marker_i(markers[g]),
            .clear_i (clear[g]),
            .last_o  (last_w[g]),
            .max_o   (max_w[g]),
            .count_o (count_w[g]),
            .ovf_o   (ovf_w[g]),
            .run_o   (run_w[g])
        );
    end

    // Unimplemented channel indices fall through and read as zero.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (addr_ch == 3'(i)) begin
                case (addr_reg)
                    REG_LAST:   sel_data = 32'(last_w[i]);
                    REG_MAX:    sel_data = 32'(max_w[i]);
                    REG_COUNT:  sel_data = 32'(count_w[i]);
                    REG_STATUS: begin
                        sel_data                 = '0;
                        sel_data[STATUS_OVF_BIT] = ovf_w[i];
                        sel_data[STATUS_RUN_BIT] = run_w[i];
                    end
                    default:    sel_data = '0;
                endcase
            end
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) readdata_d = sel_data;
    end

    always_ff @(posedge clk) begin
        if (reset) readdata_q <= '0;
        else       readdata_q <= readdata_d;
    end

    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_soc_system_benchmark_timer.sv
// Directed plus randomized bench for the benchmark timer, checked against a
// pulse-level statistics model.
module tb_soc_system_benchmark_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] markers;
    logic [1:0] markers8;
    logic [31:0] rdata;

    int checks   = 0;
    int failures = 0;

    int unsigned m_last [8];
    int unsigned m_max  [8];
    int unsigned m_cnt  [8];
    bit          m_ovf  [8];

    always #5 clk = ~clk;

    soc_system_benchmark_timer_if bus ();
    soc_system_benchmark_timer_if bus8 ();

    soc_system_benchmark_timer #(
        .N_CH (8),
        .CNT_W(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .markers(markers),
        .bus    (bus.slave)
    );

    soc_system_benchmark_timer #(
        .N_CH (2),
        .CNT_W(8)
    ) dut8 (
        .clk    (clk),
        .reset  (reset),
        .markers(markers8),
        .bus    (bus8.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.chipselect  = 1'b0; bus.read_n  = 1'b1; bus.write_n  = 1'b1;
        bus8.chipselect = 1'b0; bus8.read_n = 1'b1; bus8.write_n = 1'b1;
    endtask

    task automatic rd(input bit sel, input int ch, input int r, output logic [31:0] d);
        logic [4:0] a;
        a = {3'(ch), 2'(r)};
        if (!sel) begin
            bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        end else begin
            bus8.address = a; bus8.chipselect = 1'b1; bus8.read_n = 1'b0;
        end
        tick();
        d = sel ? bus8.readdata : bus.readdata;
        bus_idle();
    endtask

    task automatic wr(input bit sel, input int ch, input int r, input logic [31:0] data);
        logic [4:0] a;
        a = {3'(ch), 2'(r)};
        if (!sel) begin
            bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = data;
        end else begin
            bus8.address = a; bus8.chipselect = 1'b1; bus8.write_n = 1'b0; bus8.writedata = data;
        end
        tick();
        bus_idle();
    endtask

    task automatic check_reg(input bit sel, input int ch, input int r, input logic [31:0] exp,
                             input string tag);
        logic [31:0] d;
        rd(sel, ch, r, d);
        check(tag, d, exp);
    endtask

    task automatic check_ch(input int ch, input string tag);
        check_reg(0, ch, 0, m_last[ch], $sformatf("%s.ch%0d.last", tag, ch));
        check_reg(0, ch, 1, m_max[ch], $sformatf("%s.ch%0d.max", tag, ch));
        check_reg(0, ch, 2, m_cnt[ch], $sformatf("%s.ch%0d.count", tag, ch));
        check_reg(0, ch, 3, {30'd0, m_ovf[ch], 1'b0}, $sformatf("%s.ch%0d.status", tag, ch));
    endtask

    // A completed pulse of w cycles on a 32-bit channel.
    task automatic model_cap(input int ch, input int unsigned w);
        m_last[ch] = w;
        if (w > m_max[ch]) m_max[ch] = w;
        m_cnt[ch]++;
    endtask

    task automatic model_clear(input int ch);
        m_last[ch] = 0; m_max[ch] = 0; m_cnt[ch] = 0; m_ovf[ch] = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] mask, input int w);
        markers = markers | mask;
        repeat (w) tick();
        markers = markers & ~mask;
        tick();
    endtask

    initial begin
        int w [8];
        int maxw;
        logic [7:0] mask;

        reset = 1'b1;
        markers = 8'h01;
        markers8 = 2'b00;
        bus.address = '0;  bus.writedata = '0;
        bus8.address = '0; bus8.writedata = '0;
        bus_idle();
        for (int i = 0; i < 8; i++) model_clear(i);
        repeat (3) tick();
        check("reset.readdata", bus.readdata, 32'd0);

        // Marker held high across reset release must not start a run.
        reset = 1'b0;
        tick(); tick();
        check_reg(0, 0, 3, 32'd0, "hi_at_reset.status");
        check_reg(0, 0, 0, 32'd0, "hi_at_reset.last");
        markers[0] = 1'b0;
        tick();
        pulse(8'h01, 2); model_cap(0, 2);
        check_ch(0, "after_reset_pulse2");

        wr(0, 0, 3, 32'd1); model_clear(0);
        check_ch(0, "clear");

        pulse(8'h01, 5); model_cap(0, 5);
        check_ch(0, "pulse5");

        wr(0, 0, 3, 32'd1); model_clear(0);
        pulse(8'h01, 3); model_cap(0, 3); tick();
        pulse(8'h01, 7); model_cap(0, 7); tick(); tick();
        pulse(8'h01, 4); model_cap(0, 4);
        check_ch(0, "pulses_3_7_4");

        wr(0, 0, 0, 32'hFFFF_FFFF);
        wr(0, 0, 1, 32'h1);
        wr(0, 0, 2, 32'h1);
        wr(0, 0, 3, 32'hFFFF_FFFE);
        check_ch(0, "no_effect_writes");

        // Clear lands on the same edge that would capture a 6-cycle pulse.
        wr(0, 0, 3, 32'd1); model_clear(0);
        markers[0] = 1'b1;
        repeat (6) tick();
        bus.address = {3'd0, 2'd3}; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.writedata = 32'd1;
        markers[0] = 1'b0;
        tick();
        bus_idle();
        check_ch(0, "clear_vs_capture");
        pulse(8'h01, 3); model_cap(0, 3);
        check_ch(0, "after_clear_pulse3");

        // Clear mid-pulse: rest of the pulse is ignored.
        markers[1] = 1'b1;
        repeat (3) tick();
        wr(0, 1, 3, 32'd1); model_clear(1);
        repeat (3) tick();
        check_reg(0, 1, 3, 32'd0, "clear_mid_pulse.status");
        markers[1] = 1'b0;
        tick();
        check_ch(1, "clear_mid_pulse");
        pulse(8'h02, 4); model_cap(1, 4);
        check_ch(1, "clear_mid_pulse_next");

        // Read and clear of STATUS in the same cycle returns the pre-clear value.
        markers[1] = 1'b1;
        tick(); tick();
        bus.address = {3'd1, 2'd3}; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        bus.write_n = 1'b0; bus.writedata = 32'd1;
        tick();
        bus_idle();
        check("rd_clr.readdata", bus.readdata, 32'd1);
        model_clear(1);
        check_reg(0, 1, 3, 32'd0, "rd_clr.status_after");
        markers[1] = 1'b0;
        tick();
        check_ch(1, "rd_clr");

        // Channels 0 and 7 rise together and fall at different times.
        markers = markers | 8'h81;
        repeat (4) tick();
        markers[0] = 1'b0;
        repeat (5) tick();
        markers[7] = 1'b0;
        tick();
        model_cap(0, 4); model_cap(7, 9);
        check_reg(0, 7, 0, 32'd9, "dual.ch7.last");
        tick();
        check("dual.readdata_hold", bus.readdata, 32'd9);
        check_ch(0, "dual");
        check_ch(7, "dual");

        // Random overlapping pulses on all channels.
        for (int it = 0; it < 20; it++) begin
            mask = 8'($urandom_range(1, 255));
            maxw = 0;
            for (int i = 0; i < 8; i++) begin
                w[i] = mask[i] ? int'($urandom_range(1, 20)) : 0;
                if (w[i] > maxw) maxw = w[i];
            end
            markers = mask;
            for (int t = 1; t <= maxw; t++) begin
                tick();
                for (int i = 0; i < 8; i++) if (w[i] == t) markers[i] = 1'b0;
            end
            tick();
            for (int i = 0; i < 8; i++) if (w[i] != 0) model_cap(i, w[i]);
            if ($urandom_range(0, 3) == 0) begin
                int c;
                c = int'($urandom_range(0, 7));
                wr(0, c, 3, 32'd1); model_clear(c);
            end
            check_ch(int'($urandom_range(0, 7)), $sformatf("rand%0d", it));
            check_reg(0, it % 8, 0, m_last[it % 8], $sformatf("rand%0d.last", it));
        end

        // Narrow build: unimplemented channels read zero and ignore clears.
        markers8[1] = 1'b1;
        repeat (6) tick();
        markers8[1] = 1'b0;
        tick();
        check_reg(1, 1, 0, 32'd6, "n2.ch1.last");
        check_reg(1, 5, 0, 32'd0, "n2.ch5.last");
        check_reg(1, 3, 2, 32'd0, "n2.ch3.count");
        wr(1, 5, 3, 32'd1);
        wr(1, 3, 3, 32'd1);
        check_reg(1, 1, 0, 32'd6, "n2.ch1.last_kept");

        // 8-bit counters saturate and flag overflow.
        markers8[0] = 1'b1;
        repeat (300) tick();
        check_reg(1, 0, 3, 32'd3, "sat.status_running");
        markers8[0] = 1'b0;
        tick();
        check_reg(1, 0, 0, 32'd255, "sat.last");
        check_reg(1, 0, 1, 32'd255, "sat.max");
        check_reg(1, 0, 2, 32'd1, "sat.count");
        check_reg(1, 0, 3, 32'd2, "sat.status");
        wr(1, 0, 3, 32'd1);
        for (int r = 0; r < 4; r++) check_reg(1, 0, r, 32'd0, $sformatf("sat.clear.reg%0d", r));

        // Reset mid-measurement discards it.
        markers[2] = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model_clear(i);
        tick();
        check_reg(0, 2, 3, 32'd0, "mid_reset.status");
        markers[2] = 1'b0;
        tick();
        check_ch(2, "mid_reset");
        check_ch(0, "mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_system_benchmark_timer.md
SOC_SYSTEM_BENCHMARK_TIMER -- requirements
Module: soc_system_benchmark_timer

Interface
REQ-001 Parameter N_CH, default 8, number of marker channels; legal range 1..8.
REQ-002 Parameter CNT_W, default 32, width of the elapsed, max and count registers; legal range 8..32.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 markers  input  N_CH  benchmark marker bits, driven directly by the benchmark PIO out_port (same clk domain, no synchronizer).
REQ-006 address  input  5  register address: {channel[2:0], reg[1:0]}.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 read_n  input  1  active-low read strobe.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.

Function
REQ-012 Each channel SHALL register its marker into marker_q every cycle; rise = marker & ~marker_q; fall = ~marker & marker_q.
REQ-013 Each channel FSM SHALL have states IDLE and RUN.
REQ-014 IDLE + rise: elapsed <= 1, go to RUN. All other IDLE cases: hold.
REQ-015 RUN + marker high: elapsed <= elapsed+1, saturating at all-ones; on saturation, the sticky OVF bit SHALL be set.
REQ-016 RUN + marker low: LAST <= elapsed; MAX <= max(MAX, elapsed); COUNT <= COUNT+1 (saturating); go to IDLE.
REQ-017 Result: a marker pulse W cycles wide SHALL yield LAST = W, visible on the cycle after the falling edge.
REQ-018 reg 0 = LAST, reg 1 = MAX, reg 2 = COUNT, reg 3 = STATUS {bit1 OVF, bit0 RUN}; values are zero-extended to 32 bits.
REQ-019 Read: when chipselect & ~read_n, readdata SHALL update at the next edge (read latency 1); otherwise readdata holds.
REQ-020 Reads of channel index >= N_CH SHALL return 0.
REQ-021 Write: chipselect & ~write_n to reg 3 with writedata[0]=1 SHALL clear that channel's LAST, MAX, COUNT, OVF and elapsed, and force IDLE.
REQ-022 Writes to regs 0-2, to reg 3 with writedata[0]=0, or to channel >= N_CH SHALL have no effect.
REQ-023 Clear in the same cycle as a capture: clear wins; no capture is recorded.
REQ-024 Clear while the marker is high: the channel SHALL ignore the remainder of that pulse and restart only on the next rise.
REQ-025 Simultaneous read and clear of the same channel: readdata SHALL return the pre-clear value.
REQ-026 Channels SHALL operate fully independently; simultaneous edges on several channels SHALL all be handled in the same cycle.

Reset
REQ-027 reset SHALL force every channel to IDLE; elapsed, LAST, MAX, COUNT, OVF and readdata SHALL be 0.
REQ-028 reset SHALL set marker_q to all-ones, so a marker already high out of reset does not start a measurement.
REQ-029 reset asserted mid-measurement SHALL discard the measurement; no capture occurs.

Structure
REQ-030 Package soc_system_benchmark_pkg SHALL hold the register offsets (REG_LAST=0, REG_MAX=1, REG_COUNT=2, REG_STATUS=3), the FSM state encoding (IDLE, RUN) and the STATUS bit positions.
REQ-031 The per-channel edge detector, FSM and stats SHALL live in sub-module soc_system_benchmark_channel, instantiated N_CH times via generate; the top level SHALL contain only the address decode and the read mux/register.

Verification
REQ-032 Marker0 high 5 cycles then low -> LAST=5, MAX=5, COUNT=1, STATUS=0.
REQ-033 Marker0 pulses of 3, 7, then 4 cycles -> LAST=4, MAX=7, COUNT=3.
REQ-034 CNT_W=8, marker held high 300 cycles -> LAST=255, STATUS.OVF=1; then clear write (reg 3, data 1) -> all regs of that channel read 0.
REQ-035 Marker high during and after reset deassertion -> no RUN; then low, then high 2 cycles -> LAST=2, COUNT=1.
REQ-036 Clear issued on the same cycle the marker falls after 6 cycles -> LAST=0, COUNT=0; a later 3-cycle pulse -> LAST=3.
REQ-037 Markers 0 and 7 rise together, fall after 4 and 9 cycles -> ch0 LAST=4, ch7 LAST=9; read of channel 7, reg 0 returns 9 one cycle after the strobe.
